// File: rtl/cnn_stage_ctrl_if.sv
// cnn_stage_ctrl_if: pixel handshake and per-layer latch enables between the
// stream source, cnn_stage_ctrl and the conv/pool datapaths.
interface cnn_stage_ctrl_if;
  logic start;
  logic in_valid;
  logic read;
  logic S2_en;
  logic C3_en;
  logic S4_en;
  logic C5_en;
  logic busy;
  logic done;
  modport master (output start, in_valid, input read, S2_en, C3_en, S4_en, C5_en, busy, done);
  modport slave (input start, in_valid, output read, S2_en, C3_en, S4_en, C5_en, busy, done);
endinterface

// File: rtl/cnn_stage_ctrl.sv
// cnn_stage_ctrl: enable sequencer for the C1/S2/C3/S4 streaming datapath; per-layer
// coordinate counters and latency lines turn accepted pixels into one-cycle latch enables.
module cnn_stage_ctrl #(
  parameter int IMG      = 32,
  parameter int K        = 5,
  parameter int P        = 2,
  parameter int CONV_LAT = 1,
  parameter int POOL_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  cnn_stage_ctrl_if.slave bus
);
  localparam int C1 = IMG - K + 1;
  localparam int S2 = C1 / P;
  localparam int C3 = S2 - K + 1;
  localparam int F  = 2 * CONV_LAT + 2 * POOL_LAT - 1;
  localparam int W0 = $clog2(IMG);
  localparam int W1 = $clog2(C1);
  localparam int W2 = $clog2(S2);
  localparam int W3 = $clog2(C3);
  localparam int WF = $clog2(F + 1);
  // the accept edge itself is the first latency edge, so the first line is one stage short
  localparam int L1 = CONV_LAT > 1 ? CONV_LAT - 1 : 1;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [W0-1:0] r0_q, r0_d, c0_q, c0_d;
  logic [W1-1:0] r1_q, r1_d, c1_q, c1_d;
  logic [W2-1:0] r2_q, r2_d, c2_q, c2_d;
  logic [W3-1:0] r3_q, r3_d, c3_q, c3_d;
  logic [WF-1:0] fc_q, fc_d;
  logic [L1-1:0] l1_q, l1_d;
  logic [POOL_LAT-1:0] l2_q, l2_d, l4_q, l4_d;
  logic [CONV_LAT-1:0] l3_q, l3_d;
  logic [3:0] en_q, en_d, ev;
  logic clr, acc, adv, f1, f2, f3, f4, last_px;
  always_comb begin
    clr = state_q == IDLE && bus.start;
    acc = state_q == RUN && bus.in_valid;
    adv = acc || state_q == FLUSH;
    last_px = r0_q == W0'(IMG - 1) && c0_q == W0'(IMG - 1);
    f1 = acc && r0_q >= W0'(K - 1) && c0_q >= W0'(K - 1);
    ev[0] = adv && (CONV_LAT == 1 ? f1 : l1_q[L1-1]);
    f2 = ev[0] && r1_q % W1'(P) == W1'(P - 1) && c1_q % W1'(P) == W1'(P - 1);
    ev[1] = adv && l2_q[POOL_LAT-1];
    f3 = ev[1] && r2_q >= W2'(K - 1) && c2_q >= W2'(K - 1);
    ev[2] = adv && l3_q[CONV_LAT-1];
    f4 = ev[2] && r3_q % W3'(P) == W3'(P - 1) && c3_q % W3'(P) == W3'(P - 1);
    ev[3] = adv && l4_q[POOL_LAT-1];
    l1_d = clr ? '0 : adv ? L1'({l1_q, f1}) : l1_q;
    l2_d = clr ? '0 : adv ? POOL_LAT'({l2_q, f2}) : l2_q;
    l3_d = clr ? '0 : adv ? CONV_LAT'({l3_q, f3}) : l3_q;
    l4_d = clr ? '0 : adv ? POOL_LAT'({l4_q, f4}) : l4_q;
    en_d = ev;
  end
  // each stage counter steps on the edge that raises that stage's enable
  always_comb begin
    c0_d = clr ? '0 : !acc ? c0_q : c0_q == W0'(IMG - 1) ? '0 : c0_q + 1'b1;
    r0_d = clr ? '0 : !(acc && c0_q == W0'(IMG - 1)) ? r0_q : r0_q == W0'(IMG - 1) ? '0 : r0_q + 1'b1;
    c1_d = clr ? '0 : !ev[0] ? c1_q : c1_q == W1'(C1 - 1) ? '0 : c1_q + 1'b1;
    r1_d = clr ? '0 : !(ev[0] && c1_q == W1'(C1 - 1)) ? r1_q : r1_q == W1'(C1 - 1) ? '0 : r1_q + 1'b1;
    c2_d = clr ? '0 : !ev[1] ? c2_q : c2_q == W2'(S2 - 1) ? '0 : c2_q + 1'b1;
    r2_d = clr ? '0 : !(ev[1] && c2_q == W2'(S2 - 1)) ? r2_q : r2_q == W2'(S2 - 1) ? '0 : r2_q + 1'b1;
    c3_d = clr ? '0 : !ev[2] ? c3_q : c3_q == W3'(C3 - 1) ? '0 : c3_q + 1'b1;
    r3_d = clr ? '0 : !(ev[2] && c3_q == W3'(C3 - 1)) ? r3_q : r3_q == W3'(C3 - 1) ? '0 : r3_q + 1'b1;
  end
  always_comb begin
    state_d = state_q;
    fc_d = state_q == FLUSH ? fc_q + 1'b1 : '0;
    unique case (state_q)
      IDLE:    state_d = bus.start ? RUN : IDLE;
      RUN:     state_d = acc && last_px ? FLUSH : RUN;
      FLUSH:   state_d = fc_q == WF'(F - 1) ? DONE : FLUSH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fc_q <= '0;
      r0_q <= '0;
      c0_q <= '0;
      r1_q <= '0;
      c1_q <= '0;
      r2_q <= '0;
      c2_q <= '0;
      r3_q <= '0;
      c3_q <= '0;
      l1_q <= '0;
      l2_q <= '0;
      l3_q <= '0;
      l4_q <= '0;
      en_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q <= fc_d;
      r0_q <= r0_d;
      c0_q <= c0_d;
      r1_q <= r1_d;
      c1_q <= c1_d;
      r2_q <= r2_d;
      c2_q <= c2_d;
      r3_q <= r3_d;
      c3_q <= c3_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
      l4_q <= l4_d;
      en_q <= en_d;
    end
  end
  assign bus.read = state_q == RUN;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign {bus.C5_en, bus.S4_en, bus.C3_en, bus.S2_en} = en_q;
endmodule

// File: tb/tb_cnn_stage_ctrl.sv
// tb_cnn_stage_ctrl: table-driven frame checks on a default and a deeper-latency instance,
// plus hand sequences for mid-frame reset and held start.
module tb_cnn_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_v = '0;
  logic [1:0] iv_v = '0;
  always #5 clk = ~clk;
  cnn_stage_ctrl_if ifa ();
  cnn_stage_ctrl_if ifb ();
  cnn_stage_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
  cnn_stage_ctrl #(.IMG(28), .K(5), .P(2), .CONV_LAT(3), .POOL_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  assign ifa.start = start_v[0];
  assign ifa.in_valid = iv_v[0];
  assign ifb.start = start_v[1];
  assign ifb.in_valid = iv_v[1];
  logic [3:0] en_v [2];
  logic [1:0] rd_v, busy_v, done_v;
  logic [6:0] outs_v [2];
  assign en_v[0] = {ifa.C5_en, ifa.S4_en, ifa.C3_en, ifa.S2_en};
  assign en_v[1] = {ifb.C5_en, ifb.S4_en, ifb.C3_en, ifb.S2_en};
  assign rd_v = {ifb.read, ifa.read};
  assign busy_v = {ifb.busy, ifa.busy};
  assign done_v = {ifb.done, ifa.done};
  assign outs_v[0] = {ifa.read, en_v[0], ifa.busy, ifa.done};
  assign outs_v[1] = {ifb.read, en_v[1], ifb.busy, ifb.done};
  typedef struct {
    int d;
    int duty;
    int n [4];
    int first [4];
    int done_c;
  } vec_t;
  vec_t vecs [4];
  int n_tests = 0;
  int n_fail = 0;
  int cyc [2], gap [2], idle [2], adv_cnt [2], done_c [2], stall_bad [2];
  int cnt [2][4];
  int first [2][4];
  logic done_seen [2], prev_adv [2], busy_p [2], c5_at_done [2];
  logic [3:0] tr [2][1100];
  logic [3:0] tr_ref [2][1100];
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // per-cycle monitor on the falling edge: event counts, first-event cycles, stall gating, event trace
  initial begin
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; gap[d] = 0; idle[d] = 0; adv_cnt[d] = 0; done_c[d] = -1; stall_bad[d] = 0;
      done_seen[d] = 0; prev_adv[d] = 0; busy_p[d] = 0; c5_at_done[d] = 0;
      for (int e = 0; e < 4; e++) begin cnt[d][e] = 0; first[d][e] = -1; end
      for (int i = 0; i < 1100; i++) begin tr[d][i] = '0; tr_ref[d][i] = '0; end
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (busy_v[d] && !busy_p[d]) begin
          cyc[d] = 1; gap[d] = idle[d]; idle[d] = 0; adv_cnt[d] = 0; prev_adv[d] = 0;
          done_c[d] = -1; done_seen[d] = 0; stall_bad[d] = 0; c5_at_done[d] = 0;
          for (int e = 0; e < 4; e++) begin cnt[d][e] = 0; first[d][e] = -1; end
          for (int i = 0; i < 1100; i++) tr[d][i] = '0;
        end else if (busy_v[d]) cyc[d]++;
        if (!busy_v[d]) idle[d]++;
        if (busy_v[d]) begin
          if (en_v[d] != 4'd0 && !prev_adv[d]) stall_bad[d]++;
          if (prev_adv[d] && adv_cnt[d] < 1100) tr[d][adv_cnt[d]] = en_v[d];
          for (int e = 0; e < 4; e++)
            if (en_v[d][e]) begin
              cnt[d][e]++;
              if (first[d][e] < 0) first[d][e] = cyc[d];
            end
          if (done_v[d]) begin done_seen[d] = 1; done_c[d] = cyc[d]; c5_at_done[d] = en_v[d][3]; end
          prev_adv[d] = (rd_v[d] && iv_v[d]) || (!rd_v[d] && !done_v[d]);
          if (prev_adv[d]) adv_cnt[d]++;
        end
        busy_p[d] = busy_v[d];
      end
    end
  end
  task automatic wait_done(input int d, input int duty);
    for (int k = 0; k < 20000; k++) begin
      iv_v[d] = $urandom_range(0, 99) < duty;
      @(posedge clk); #1;
      if (done_seen[d]) break;
    end
    iv_v[d] = 1'b0;
    chk("frame_completes", int'(done_seen[d]), 1);
  endtask
  task automatic run_frame(input int d, input int duty);
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    wait_done(d, duty);
  endtask
  task automatic chk_counts(input string tag, input int d, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_S2_cnt"}, cnt[d][0], e0);
    chk({tag, "_C3_cnt"}, cnt[d][1], e1);
    chk({tag, "_S4_cnt"}, cnt[d][2], e2);
    chk({tag, "_C5_cnt"}, cnt[d][3], e3);
  endtask
  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int mism;
    vecs[0] = '{d: 0, duty: 100, n: '{784, 196, 100, 25}, first: '{134, 168, 433, 500}, done_c: 1028};
    vecs[1] = '{d: 0, duty: 30,  n: '{784, 196, 100, 25}, first: '{-1, -1, -1, -1}, done_c: -1};
    vecs[2] = '{d: 1, duty: 100, n: '{576, 144, 64, 16},  first: '{120, 151, 386, 446}, done_c: 794};
    vecs[3] = '{d: 1, duty: 40,  n: '{576, 144, 64, 16},  first: '{-1, -1, -1, -1}, done_c: -1};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_a", int'(outs_v[0]), 0);
    chk("reset_outs_b", int'(outs_v[1]), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].d, vecs[v].duty);
      chk_counts($sformatf("v%0d", v), vecs[v].d, vecs[v].n[0], vecs[v].n[1], vecs[v].n[2], vecs[v].n[3]);
      chk($sformatf("v%0d_stall_gating", v), stall_bad[vecs[v].d], 0);
      if (vecs[v].done_c >= 0) begin
        for (int e = 0; e < 4; e++) chk($sformatf("v%0d_first_en%0d", v, e), first[vecs[v].d][e], vecs[v].first[e]);
        chk($sformatf("v%0d_done_cycle", v), done_c[vecs[v].d], vecs[v].done_c);
        chk($sformatf("v%0d_c5_with_done", v), int'(c5_at_done[vecs[v].d]), 1);
        for (int i = 0; i < 1100; i++) tr_ref[vecs[v].d][i] = tr[vecs[v].d][i];
      end else begin
        mism = 0;
        for (int i = 0; i < 1100; i++) if (tr[vecs[v].d][i] != tr_ref[vecs[v].d][i]) mism++;
        chk($sformatf("v%0d_event_order", v), mism, 0);
      end
      @(posedge clk); #1;
    end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    iv_v[0] = 1'b1;
    for (int k = 0; k < 2000 && cyc[0] < 500; k++) begin @(posedge clk); #1; end
    chk("mid_rst_reached", int'(cyc[0] >= 500 && busy_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs_a", int'(outs_v[0]), 0);
    chk("mid_rst_outs_b", int'(outs_v[1]), 0);
    iv_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_idle", int'(busy_v[0]), 0);
    run_frame(0, 100);
    chk_counts("after_rst", 0, 784, 196, 100, 25);
    chk("after_rst_done_cycle", done_c[0], 1028);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 100);
    chk_counts("held_start_f1", 0, 784, 196, 100, 25);
    chk("held_start_f1_done", done_c[0], 1028);
    chk("held_start_idle_cycle", int'(busy_v[0]), 0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    chk("held_start_restart", int'(rd_v[0]), 1);
    wait_done(0, 100);
    chk_counts("held_start_f2", 0, 784, 196, 100, 25);
    chk("held_start_f2_done", done_c[0], 1028);
    chk("held_start_gap", gap[0], 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
